switch_to_note_arp: RTL and testbench

Parametrised successor to the switch-to-note mapper. Snapshots a root note, a switch bank and a scale mode, then produces a registered note bus with one slot per switch. A built-in arpeggiator steps through the active notes on an external beat pulse. It sits between the switch/debounce front end and the note player, which consumes either the chord bus or the single arpeggio note.

---
 rtl/note_pkg.sv | 49 ++++
 rtl/note_slot_scan.sv | 43 ++++
 rtl/switch_to_note_arp.sv | 171 +++++++++++++++++
 tb/tb_switch_to_note_arp.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/note_pkg.sv
// Shared types and scale tables for the switch-to-note mapper and arpeggiator.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package note_pkg;

  localparam int NOTE_REST = 0;

  typedef enum logic [1:0] {
    MODE_MAJOR = 2'd0,
    MODE_MINOR = 2'd1,
    MODE_CHROM = 2'd2,
    MODE_PENTA = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ARP_UP     = 2'd0,
    ARP_DOWN   = 2'd1,
    ARP_BOUNCE = 2'd2,
    ARP_HOLD   = 2'd3
  } arp_dir_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    PLAY  = 2'd2
  } state_e;

  // Semitone offsets from the root for the first octave of slots.
  localparam logic [4:0] IV_MAJOR [8] = '{5'd0, 5'd2, 5'd4, 5'd5, 5'd7, 5'd9, 5'd11, 5'd12};
  localparam logic [4:0] IV_MINOR [8] = '{5'd0, 5'd2, 5'd3, 5'd5, 5'd7, 5'd8, 5'd10, 5'd12};
  localparam logic [4:0] IV_CHROM [8] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7};
  localparam logic [4:0] IV_PENTA [8] = '{5'd0, 5'd2, 5'd4, 5'd7, 5'd9, 5'd12, 5'd14, 5'd16};

  // Interval of slot i: table entry for i mod 8, raised one octave per
  // completed group of eight slots.
  function automatic logic [15:0] interval(input mode_e m, input int unsigned i);
    logic [2:0] k;
    logic [4:0] base;
    k = 3'(i % 8);
    case (m)
      MODE_MAJOR: base = IV_MAJOR[k];
      MODE_MINOR: base = IV_MINOR[k];
      MODE_CHROM: base = IV_CHROM[k];
      default:    base = IV_PENTA[k];
    endcase
    return 16'(base) + 16'(12 * (i / 8));
  endfunction

endpackage

// File: rtl/note_slot_scan.sv
// Finds the next set bit of mask after idx, searching up or down with wrap.
// Latency: combinational.
// Backpressure: none.
// Ports: mask/idx/down in; nxt = next active slot (idx if mask empty),
//        wrapped = no active slot strictly beyond idx in that direction.
module note_slot_scan
  import note_pkg::*;
#(
  parameter int NUM_SW = 8,
  parameter int IDX_W  = 3
) (
  input  logic [NUM_SW-1:0] mask,
  input  logic [IDX_W-1:0]  idx,
  input  logic              down,
  output logic [IDX_W-1:0]  nxt,
  output logic              wrapped
);

  int               j;
  logic             found;
  logic [IDX_W-1:0] jj;

  always_comb begin
    nxt     = idx;
    wrapped = 1'b1;
    found   = 1'b0;
    j       = 0;
    jj      = '0;
    // Distance k = NUM_SW lands back on idx itself, so a lone active slot
    // returns itself flagged as wrapped.
    for (int k = 1; k <= NUM_SW; k++) begin
      if (down) j = (int'(idx) + NUM_SW - k) % NUM_SW;
      else      j = (int'(idx) + k) % NUM_SW;
      jj = IDX_W'(j);
      if (!found && mask[jj]) begin
        found   = 1'b1;
        nxt     = jj;
        wrapped = down ? (k > int'(idx)) : ((int'(idx) + k) >= NUM_SW);
      end
    end
  end

endmodule

// File: rtl/switch_to_note_arp.sv
// Snapshot root/switches/mode into a chord bus and arpeggiate its active notes.
// Latency: 1 cycle load->notes/active_mask/first arp_note; 1 cycle advance->arp_note.
// Backpressure: none; load and advance are pulses, all outputs are registered levels.
// Ports: clk, rst (sync, high); load, root, switches, mode snapshot the chord;
//        arp_dir, advance drive stepping; notes, active_mask, arp_note, arp_valid out.
module switch_to_note_arp
  import note_pkg::*;
#(
  parameter int NUM_SW   = 8,
  parameter int NOTE_W   = 6,
  parameter int MAX_NOTE = 63
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load,
  input  logic [NOTE_W-1:0]        root,
  input  logic [NUM_SW-1:0]        switches,
  input  logic [1:0]               mode,
  input  logic [1:0]               arp_dir,
  input  logic                     advance,
  output logic [NUM_SW*NOTE_W-1:0] notes,
  output logic [NOTE_W-1:0]        arp_note,
  output logic                     arp_valid,
  output logic [NUM_SW-1:0]        active_mask
);

  localparam int IDX_W = (NUM_SW > 1) ? $clog2(NUM_SW) : 1;
  // Four spare bits keep root+interval from wrapping before the range test.
  localparam int SUM_W = NOTE_W + 4;

  state_e            state;
  logic [NOTE_W-1:0] slot_q [NUM_SW];
  logic [IDX_W-1:0]  idx_q;
  logic              dir_dn_q;   // bounce direction, 0 = moving up

  logic [NOTE_W-1:0] calc_note [NUM_SW];
  logic [NUM_SW-1:0] calc_mask;
  logic [SUM_W-1:0]  sum;
  logic [IDX_W-1:0]  first_idx;

  logic [IDX_W-1:0]  up_nxt, dn_nxt, step_idx;
  logic              up_wrap, dn_wrap, step_dn;
  arp_dir_e          dir;

  assign dir = arp_dir_e'(arp_dir);

  // Chord computed straight from the inputs so the load cycle can register
  // both the bus and the first arpeggio note.
  always_comb begin
    sum       = '0;
    calc_mask = '0;
    for (int i = 0; i < NUM_SW; i++) begin
      calc_note[i] = NOTE_W'(NOTE_REST);
      sum = SUM_W'(root) + SUM_W'(interval(mode_e'(mode), i));
      if (switches[i] && (sum <= SUM_W'(MAX_NOTE))) begin
        calc_note[i] = sum[NOTE_W-1:0];
        calc_mask[i] = 1'b1;
      end
    end
  end

  function automatic logic [IDX_W-1:0] first_active(input logic [NUM_SW-1:0] m,
                                                     input logic highest);
    logic [IDX_W-1:0] r;
    r = '0;
    // Later hits overwrite earlier ones, so scan order picks the extreme.
    for (int i = 0; i < NUM_SW; i++) begin
      if (highest && m[i]) r = IDX_W'(i);
      if (!highest && m[NUM_SW-1-i]) r = IDX_W'(NUM_SW-1-i);
    end
    return r;
  endfunction

  always_comb begin
    first_idx = first_active(calc_mask, (dir == ARP_DOWN) || (dir == ARP_HOLD));
  end

  note_slot_scan #(.NUM_SW(NUM_SW), .IDX_W(IDX_W)) u_scan_up (
    .mask    (active_mask),
    .idx     (idx_q),
    .down    (1'b0),
    .nxt     (up_nxt),
    .wrapped (up_wrap)
  );

  note_slot_scan #(.NUM_SW(NUM_SW), .IDX_W(IDX_W)) u_scan_dn (
    .mask    (active_mask),
    .idx     (idx_q),
    .down    (1'b1),
    .nxt     (dn_nxt),
    .wrapped (dn_wrap)
  );

  // Next index for one beat. Bounce turns at either end and takes one step
  // the other way, so the end note is not repeated; a lone slot stays put.
  always_comb begin
    step_idx = idx_q;
    step_dn  = 1'b0;
    case (dir)
      ARP_UP:   step_idx = up_nxt;
      ARP_DOWN: step_idx = dn_nxt;
      ARP_BOUNCE: begin
        step_dn = dir_dn_q;
        if (!dir_dn_q) begin
          if (!up_wrap) step_idx = up_nxt;
          else begin
            step_dn = 1'b1;
            if (!dn_wrap) step_idx = dn_nxt;
          end
        end else begin
          if (!dn_wrap) step_idx = dn_nxt;
          else begin
            step_dn = 1'b0;
            if (!up_wrap) step_idx = up_nxt;
          end
        end
      end
      default: step_idx = idx_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      idx_q       <= '0;
      dir_dn_q    <= 1'b0;
      active_mask <= '0;
      arp_note    <= '0;
      arp_valid   <= 1'b0;
      for (int i = 0; i < NUM_SW; i++) slot_q[i] <= '0;
    end else begin
      // Outside bounce the flag is held at "up", so entering bounce starts upward.
      if (dir != ARP_BOUNCE) dir_dn_q <= 1'b0;

      if (load) begin
        for (int i = 0; i < NUM_SW; i++) slot_q[i] <= calc_note[i];
        active_mask <= calc_mask;
        dir_dn_q    <= 1'b0;
        if (|calc_mask) begin
          state     <= START;
          idx_q     <= first_idx;
          arp_note  <= calc_note[first_idx];
          arp_valid <= 1'b1;
        end else begin
          state     <= IDLE;
          idx_q     <= '0;
          arp_note  <= NOTE_W'(NOTE_REST);
          arp_valid <= 1'b0;
        end
      end else begin
        case (state)
          IDLE:  state <= IDLE;
          START: state <= PLAY;
          PLAY: begin
            if (advance) begin
              idx_q    <= step_idx;
              dir_dn_q <= step_dn;
              arp_note <= slot_q[step_idx];
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  for (genvar g = 0; g < NUM_SW; g++) begin : g_flat
    assign notes[g*NOTE_W +: NOTE_W] = slot_q[g];
  end

endmodule

// File: tb/tb_switch_to_note_arp.sv
// Bench for switch_to_note_arp: directed loads/beats with a queue-based model
// checked every cycle, plus literal expectations for the documented cases.
module tb_switch_to_note_arp;

  localparam int NUM_SW   = 8;
  localparam int NOTE_W   = 6;
  localparam int MAX_NOTE = 63;

  logic                     clk = 1'b0;
  logic                     rst, load, advance;
  logic [NOTE_W-1:0]        root;
  logic [NUM_SW-1:0]        switches;
  logic [1:0]               mode, arp_dir;
  logic [NUM_SW*NOTE_W-1:0] notes;
  logic [NOTE_W-1:0]        arp_note;
  logic                     arp_valid;
  logic [NUM_SW-1:0]        active_mask;

  switch_to_note_arp #(.NUM_SW(NUM_SW), .NOTE_W(NOTE_W), .MAX_NOTE(MAX_NOTE)) dut (
    .clk(clk), .rst(rst), .load(load), .root(root), .switches(switches),
    .mode(mode), .arp_dir(arp_dir), .advance(advance), .notes(notes),
    .arp_note(arp_note), .arp_valid(arp_valid), .active_mask(active_mask)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  function automatic void check(input string name, input logic [63:0] got, input logic [63:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, got, got, want, want, $time);
    end
  endfunction

  // ---------------- behavioural model ----------------
  int tbl [4][8] = '{'{0, 2, 4, 5, 7, 9, 11, 12},
                     '{0, 2, 3, 5, 7, 8, 10, 12},
                     '{0, 1, 2, 3, 4, 5, 6, 7},
                     '{0, 2, 4, 7, 9, 12, 14, 16}};

  logic [NUM_SW-1:0][NOTE_W-1:0] m_notes;
  logic [NUM_SW-1:0]             m_mask;
  int                            act[$];   // active slot numbers, ascending
  int                            pos;      // position within act
  bit                            m_down, m_live, m_fresh, m_valid;
  logic [NOTE_W-1:0]             m_note;

  always @(posedge clk) begin
    int n;
    if (rst) begin
      m_notes = '0; m_mask = '0; act.delete(); pos = 0;
      m_down = 0; m_live = 0; m_fresh = 0; m_valid = 0; m_note = '0;
    end else begin
      if (arp_dir != 2'd2) m_down = 0;
      if (load) begin
        act.delete(); m_notes = '0; m_mask = '0; m_down = 0; m_fresh = 0;
        for (int i = 0; i < NUM_SW; i++) begin
          int s;
          s = int'(root) + tbl[mode][i % 8] + 12 * (i / 8);
          if (switches[i] && s <= MAX_NOTE) begin
            m_notes[i] = NOTE_W'(s);
            m_mask[i]  = 1'b1;
            act.push_back(i);
          end
        end
        if (act.size() == 0) begin
          m_live = 0; m_valid = 0; m_note = '0;
        end else begin
          pos     = (arp_dir == 2'd0 || arp_dir == 2'd2) ? 0 : act.size() - 1;
          m_live  = 1; m_fresh = 1; m_valid = 1;
          m_note  = m_notes[act[pos]];
        end
      end else if (m_fresh) begin
        m_fresh = 0;
      end else if (m_live && advance) begin
        n = act.size();
        case (arp_dir)
          2'd0: pos = (pos + 1) % n;
          2'd1: pos = (pos + n - 1) % n;
          2'd2: if (n > 1) begin
            if (!m_down) begin
              if (pos == n - 1) begin m_down = 1; pos--; end else pos++;
            end else begin
              if (pos == 0) begin m_down = 0; pos++; end else pos--;
            end
          end
          default: ;
        endcase
        m_note = m_notes[act[pos]];
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_notes", notes, m_notes);
      check("model_mask", active_mask, m_mask);
      check("model_arp_valid", arp_valid, m_valid);
      check("model_arp_note", arp_note, m_note);
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load_cfg(input int r, input logic [7:0] sw, input int md, input int dr);
    root = NOTE_W'(r); switches = sw; mode = 2'(md); arp_dir = 2'(dr);
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic step();
    advance = 1'b1;
    @(negedge clk);
    advance = 1'b0;
  endtask

  logic [NUM_SW-1:0][NOTE_W-1:0] lit;
  int exp_up [6] = '{2, 9, 12, 2, 9, 12};
  int exp_dn [4] = '{12, 9, 2, 12};
  int exp_bn [7] = '{2, 9, 12, 9, 2, 9, 12};

  initial begin
    rst = 1'b1; load = 1'b0; advance = 1'b0;
    root = '0; switches = '0; mode = '0; arp_dir = '0;
    idle(2);
    chk_en = 1'b1;
    check("reset_notes", notes, 0);
    check("reset_mask", active_mask, 0);
    check("reset_arp_valid", arp_valid, 0);
    check("reset_arp_note", arp_note, 0);
    rst = 1'b0;
    idle(1);

    // Case 1: major from root 0
    load_cfg(0, 8'b10100010, 0, 0);
    lit = '0; lit[1] = 6'd2; lit[5] = 6'd9; lit[7] = 6'd12;
    check("c1_notes", notes, lit);
    check("c1_mask", active_mask, 8'b10100010);
    check("c1_first_arp", arp_note, 2);
    check("c1_arp_valid", arp_valid, 1);

    // Case 2: root 23
    load_cfg(23, 8'b10100010, 0, 0);
    lit = '0; lit[1] = 6'd25; lit[5] = 6'd32; lit[7] = 6'd35;
    check("c2_notes", notes, lit);

    // Case 3: range limit mutes upper slots
    load_cfg(60, 8'hFF, 0, 0);
    lit = '0; lit[0] = 6'd60; lit[1] = 6'd62;
    check("c3_notes", notes, lit);
    check("c3_mask", active_mask, 8'b00000011);

    // Other scales
    load_cfg(10, 8'hFF, 1, 0);
    check("minor_slot2", notes[17:12], 13);
    check("minor_slot7", notes[47:42], 22);
    load_cfg(50, 8'hFF, 3, 0);
    check("penta_mask", active_mask, 8'h3F);
    check("penta_slot5", notes[35:30], 62);
    load_cfg(62, 8'h0F, 2, 0);
    check("chrom_mask_at_max", active_mask, 8'h03);
    check("chrom_slot1_63", notes[11:6], 63);

    // Inputs without load are ignored
    root = 6'd5; switches = 8'hFF; mode = 2'd3;
    idle(3);
    check("ignore_inputs_slot1", notes[11:6], 63);

    // Case 4: up
    load_cfg(0, 8'b10100010, 0, 0);
    check("up_0", arp_note, exp_up[0]);
    idle(1);
    for (int k = 1; k < 6; k++) begin
      step();
      check($sformatf("up_%0d", k), arp_note, exp_up[k]);
    end
    // down, with a beat during START that must be dropped
    load_cfg(0, 8'b10100010, 0, 1);
    check("dn_0", arp_note, exp_dn[0]);
    step();
    check("start_ignores_advance", arp_note, 12);
    for (int k = 1; k < 4; k++) begin
      step();
      check($sformatf("dn_%0d", k), arp_note, exp_dn[k]);
    end
    // bounce
    load_cfg(0, 8'b10100010, 0, 2);
    check("bn_0", arp_note, exp_bn[0]);
    idle(1);
    for (int k = 1; k < 7; k++) begin
      step(); idle(1);
      check($sformatf("bn_%0d", k), arp_note, exp_bn[k]);
    end
    // hold
    load_cfg(0, 8'b10100010, 0, 3);
    idle(1);
    repeat (3) step();
    check("hold_note", arp_note, 12);

    // Direction changes mid-play
    load_cfg(0, 8'b10100010, 0, 1);
    idle(1);
    step();
    check("chg_down", arp_note, 9);
    arp_dir = 2'd2;
    step();
    check("chg_bounce_starts_up", arp_note, 12);
    step();
    check("chg_bounce_turns", arp_note, 9);
    arp_dir = 2'd0;
    step();
    check("chg_up", arp_note, 12);
    step();
    check("chg_up_wrap", arp_note, 2);

    // Single active slot repeats
    load_cfg(40, 8'h10, 0, 2);
    idle(1);
    step(); step();
    check("single_note", arp_note, 47);
    check("single_valid", arp_valid, 1);

    // Case 5: empty reload goes idle; load beats a simultaneous advance
    load_cfg(0, 8'h00, 0, 0);
    check("empty_valid", arp_valid, 0);
    check("empty_mask", active_mask, 0);
    step();
    check("idle_ignores_advance", arp_note, 0);
    load_cfg(0, 8'b10100010, 0, 0);
    idle(1);
    step();
    check("pre_reload_step", arp_note, 9);
    advance = 1'b1;
    load_cfg(0, 8'b10100010, 0, 0);
    advance = 1'b0;
    check("load_over_advance", arp_note, 2);
    idle(1);
    check("load_over_advance_hold", arp_note, 2);

    // Case 6: reset with advance mid-play
    step();
    check("pre_reset_step", arp_note, 9);
    rst = 1'b1; advance = 1'b1;
    @(negedge clk);
    rst = 1'b0; advance = 1'b0;
    check("rst_notes", notes, 0);
    check("rst_mask", active_mask, 0);
    check("rst_arp_valid", arp_valid, 0);
    check("rst_arp_note", arp_note, 0);
    step();
    check("post_rst_advance_valid", arp_valid, 0);
    check("post_rst_advance_note", arp_note, 0);

    idle(2);
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
